// File: rtl/register_16_bit_pkg.sv
// register_16_bit_pkg
// Shared constants and types for the 16-bit datapath holding register.
//   DATA_W              : nominal data width (16)
//   RESET_VALUE_DEFAULT : value loaded by a synchronous clear
//   data_t              : one data word
package register_16_bit_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

  localparam data_t RESET_VALUE_DEFAULT = 16'h0000;

endpackage : register_16_bit_pkg

// File: rtl/register_16_bit.sv
// register_16_bit
// Edge-triggered data register with load enable and synchronous clear.
// Used as the pipeline / holding register in the datapath, e.g. to hold
// the product of the 8x8 multiplier.
//
// Ports:
//   clk        in   rising-edge clock
//   sclr       in   synchronous clear, active-high (wins over clk_ena)
//   clk_ena    in   load enable, active-high
//   datain     in   [WIDTH-1:0] word to capture
//   reg_out    out  [WIDTH-1:0] registered word, driven straight from flops
//   reg_parity out  XOR reduction of the stored word
//                   (only when REGISTER_16_BIT_PARITY_EN is defined)
//
// Configuration macro: REGISTER_16_BIT_PARITY_EN
module register_16_bit
  import register_16_bit_pkg::*;
#(
  parameter int unsigned       WIDTH       = DATA_W,
  parameter logic [WIDTH-1:0]  RESET_VALUE = RESET_VALUE_DEFAULT
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] datain,
`ifdef REGISTER_16_BIT_PARITY_EN
  output logic             reg_parity,
`endif
  output logic [WIDTH-1:0] reg_out
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;

  // Load path only; clear is applied in the flop process so that it wins
  // regardless of clk_ena and never looks at datain.
  always_comb begin
    reg_d = reg_q;
    if (clk_ena) begin
      reg_d = datain;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      reg_q <= RESET_VALUE;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign reg_out = reg_q;

`ifdef REGISTER_16_BIT_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity is computed from the incoming word so it is registered
  // alongside the data rather than derived from reg_q combinationally.
  always_comb begin
    parity_d = parity_q;
    if (clk_ena) begin
      parity_d = ^datain;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      parity_q <= ^RESET_VALUE;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign reg_parity = parity_q;
`endif

endmodule : register_16_bit

// File: tb/tb_register_16_bit.sv
// tb_register_16_bit
// Self-checking bench for register_16_bit: directed test-plan vectors
// followed by randomized sclr/clk_ena/datain traffic checked against a
// behavioural model of the register contents.
module tb_register_16_bit;

  localparam logic [15:0] RST_VAL = 16'h0000;

  logic        clk;
  logic        sclr;
  logic        clk_ena;
  logic [15:0] datain;
  logic [15:0] reg_out;
`ifdef REGISTER_16_BIT_PARITY_EN
  logic        reg_parity;
`endif

  int unsigned n_vec;
  int unsigned n_err;

  // Model: the word the register should hold.
  logic [15:0] model_word;

  register_16_bit #(
    .WIDTH       (16),
    .RESET_VALUE (RST_VAL)
  ) dut (
    .clk        (clk),
    .sclr       (sclr),
    .clk_ena    (clk_ena),
    .datain     (datain),
`ifdef REGISTER_16_BIT_PARITY_EN
    .reg_parity (reg_parity),
`endif
    .reg_out    (reg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, update the model, then sample
  // 1 time unit after the edge.
  task automatic step(input logic s, input logic e, input logic [15:0] d,
                      input string tag);
    sclr    = s;
    clk_ena = e;
    datain  = d;
    @(posedge clk);
    if (s)      model_word = RST_VAL;
    else if (e) model_word = d;
    #1;
    check(tag, reg_out, model_word);
`ifdef REGISTER_16_BIT_PARITY_EN
    check({tag, "_par"}, {15'd0, reg_parity}, {15'd0, ^model_word});
`endif
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    model_word = 'x;
    sclr       = 1'b0;
    clk_ena    = 1'b0;
    datain     = '0;
    @(posedge clk);
    #1;

    // Clear with enable: clear wins over load.
    step(1'b1, 1'b1, 16'h1234, "clr_ena");
    // Load.
    step(1'b0, 1'b1, 16'h1234, "load");
    // Hold for three edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h1454, "hold");
    // Clear while disabled.
    step(1'b1, 1'b0, 16'h1454, "clr_dis");
    // Back-to-back loads.
    step(1'b0, 1'b1, 16'hFFFF, "b2b_0");
    step(1'b0, 1'b1, 16'h0001, "b2b_1");
    step(1'b0, 1'b1, 16'hA5A5, "b2b_2");

    // Mid-cycle glitch on datain and clk_ena, restored before the edge.
    sclr    = 1'b0;
    clk_ena = 1'b0;
    datain  = 16'h0F0F;
    #1;
    clk_ena = 1'b1;
    datain  = 16'h1111;
    #1;
    clk_ena = 1'b0;
    datain  = 16'h0F0F;
    #1;
    check("glitch_mid", reg_out, 16'hA5A5);
    step(1'b0, 1'b0, 16'h0F0F, "glitch_edge");

    // Unknown data must not leak in while holding or clearing.
    step(1'b0, 1'b0, 'x, "x_hold");
    step(1'b1, 1'b0, 'x, "x_clr_dis");
    step(1'b1, 1'b1, 'x, "x_clr_ena");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
           16'($urandom), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_register_16_bit
